ar_freeze_ctrl: RTL and testbench
=================================

// Module: ar_freeze_ctrl
// PURPOSE
//  Sequences Action Replay freeze entry/exit for the cartridge datapath.
//  - Arbitrates three INT7 sources by fixed priority: freeze button, breakpoint, reset trap.
//  - Drives INT7, waits for the autovector acknowledge, then raises the chip-RAM overlay and cartridge-active flags.
//  - Retires each flag when the cartridge ROM code writes its exit register.
//  - Sits between the cartridge address decoder and the CPU interrupt/IPL logic.
// PARAMETERS
//  VEC_ADDR     23'h000004  word address of the reset-trap access (byte $8)
//  BRK_ADDR     23'h5FF000  word address of the breakpoint access (byte $BFE001)
//  ACK_TIMEOUT  255         clk cycles INT7 may stay pending before it is abandoned (1..255)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-low
//  aron         in   1   cartridge ROM loaded/enabled
//  boot         in   1   bootloader running; all requests are masked while high
//  freeze       in   1   freeze key, level, synchronous to clk
//  brk_en       in   1   breakpoint circuit enabled (mode bit 1)
//  cpu_address  in   23  CPU address [23:1]
//  cpu_as_n     in   1   CPU address strobe, active-low, synchronous to clk
//  cpu_rd       in   1   CPU read cycle
//  exit_ovl     in   1   decoded CPU write to $400006 (one clk pulse)
//  exit_act     in   1   decoded CPU write to $400000 (one clk pulse)
//  int7         out  1   level-7 interrupt request
//  ovl          out  1   chip-RAM overlay enable
//  active       out  1   cartridge ROM/RAM visible
//  status       out  2   freeze cause: 00 button, 01 breakpoint, 11 reset trap
//  ack_err      out  1   sticky flag: INT7 timed out without an acknowledge
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - state=IDLE; int7=0, ovl=0, active=0, ack_err=0, status=11.
//   - Arms rst_trap=1 and clears the hit flag.
//  Request sources (a source is ignored unless aron=1 and boot=0):
//   - fz_req:  rising edge of freeze, only while active=0.
//   - brk_req: brk_en=1, hit=1, cpu_address==BRK_ADDR, cpu_as_n=0.
//   - rst_req: rst_trap=1, cpu_address==VEC_ADDR, cpu_as_n=0.
//   - Priority fz > brk > rst. A request seen outside IDLE is dropped, not queued.
//  hit: updated on every rising edge of cpu_as_n; set if the address of the cycle just ended had bits [23:10]==0.
//  ack: cpu_as_n=0, cpu_rd=1, cpu_address all ones. Counted once per bus cycle (falling edge of the qualified term).
//  States:
//   - IDLE: on a request, go to REQ next clk.
//     int7=1 from that edge; status takes the cause (fz->00, brk->01, rst->11); timer loads ACK_TIMEOUT.
//   - REQ: timer decrements every clk.
//     ack -> FROZEN; int7=0, ovl=1, active=1, rst_trap=0.
//     Timer reaches 0 first -> IDLE; int7=0, ack_err=1.
//     If ack and timer 0 occur in the same clk, ack wins.
//   - FROZEN: exit_ovl -> ovl=0, go to RESUME.
//     exit_act alone -> active=0 and ovl=0, go to IDLE.
//   - RESUME: exit_act -> active=0, go to IDLE.
//     A second fz_req is impossible here (active=1); brk_req is ignored.
//   - exit_ovl and exit_act in the same clk (in FROZEN or RESUME): both flags clear, go to IDLE.
//  - aron falling in any state: int7=0, go to IDLE next clk; ovl and active are cleared.
//  - Latency: request to int7 = 1 clk; ack to ovl/active = 1 clk.
// STRUCTURE
//  - Shared package ar_pkg:
//    - state enum (IDLE, REQ, FROZEN, RESUME).
//    - status codes AR_ST_FREEZE=2'b00, AR_ST_BREAK=2'b01, AR_ST_RESET=2'b11.
//    - AR_INT7_ACK_ADDR = all ones.
//  - One sub-module, ar_req_arb: edge detection, hit flag, rst_trap and priority encode.
//    Outputs: req, cause[1:0].
//  - FSM, timer and output flags stay in ar_freeze_ctrl.
// TESTING
//  1. Reset trap: after reset, aron=1, access at byte $8 -> int7 next clk, status=11.
//     Ack cycle -> ovl=1, active=1. A second $8 access after exit raises no int7.
//  2. Freeze: pulse freeze -> int7, status=00; ack -> FROZEN.
//     exit_ovl -> ovl=0 (RESUME); exit_act -> active=0, IDLE.
//     A freeze edge while active=1 is ignored.
//  3. Breakpoint: brk_en=1, prior cycle at $000200, then read $BFE001 -> int7, status=01.
//     Same access with prior cycle at $000400 -> no int7.
//  4. Priority: freeze edge and breakpoint access in the same clk -> status=00, a single int7.
//  5. Timeout: request with no ack for 255 clk -> int7 drops, ack_err=1, state IDLE.
//     Ack on the final timer clk -> FROZEN, ack_err stays 0.
//  6. Masking and abort:
//     - boot=1 or aron=0 -> no int7 from any source.
//     - Drop aron in FROZEN -> ovl=0, active=0, IDLE.
//     - reset=0 in REQ -> all outputs at reset values next clk.

Source files
------------

// File: rtl/ar_pkg.sv
// Shared definitions for the Action Replay freeze controller.
//  - ar_state_e        : freeze sequencer states
//  - AR_ST_*           : freeze cause codes reported on status
//  - AR_INT7_ACK_ADDR  : CPU word address of the level-7 autovector acknowledge
package ar_pkg;

  typedef enum logic [1:0] {
    AR_IDLE   = 2'd0,
    AR_REQ    = 2'd1,
    AR_FROZEN = 2'd2,
    AR_RESUME = 2'd3
  } ar_state_e;

  localparam logic [1:0] AR_ST_FREEZE = 2'b00;
  localparam logic [1:0] AR_ST_BREAK  = 2'b01;
  localparam logic [1:0] AR_ST_RESET  = 2'b11;

  localparam logic [22:0] AR_INT7_ACK_ADDR = '1;

endpackage

// File: rtl/ar_req_arb.sv
// INT7 request arbiter for the Action Replay freeze controller.
// Detects freeze-key edges, tracks the low-memory "hit" flag used to qualify
// breakpoints, holds the one-shot reset trap and priority-encodes the sources.
//  clk, reset   : clock, synchronous active-low reset
//  aron, boot   : cartridge enabled / bootloader running (masks all requests)
//  freeze       : freeze key level
//  brk_en       : breakpoint circuit enabled
//  cpu_address  : CPU word address [23:1]
//  cpu_as_n     : CPU address strobe, active-low
//  active       : cartridge currently active (blocks freeze edges)
//  trap_clr     : disarm the reset trap (freeze entry acknowledged)
//  req          : a qualified request is present this clk
//  cause        : status code of the highest-priority source
module ar_req_arb
  import ar_pkg::*;
#(
  parameter logic [22:0] VEC_ADDR = 23'h000004,
  parameter logic [22:0] BRK_ADDR = 23'h5FF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        aron,
  input  logic        boot,
  input  logic        freeze,
  input  logic        brk_en,
  input  logic [22:0] cpu_address,
  input  logic        cpu_as_n,
  input  logic        active,
  input  logic        trap_clr,
  output logic        req,
  output logic [1:0]  cause
);

  logic freeze_q;
  logic as_n_q;
  logic low_blk_q;   // address of the current bus cycle lies below byte $400
  logic hit_q;
  logic rst_trap_q;
  logic as_rise;
  logic fz_req;
  logic brk_req;
  logic rst_req;

  // History samples need no reset: they only feed edge detectors.
  always_ff @(posedge clk) begin
    freeze_q <= freeze;
    as_n_q   <= cpu_as_n;
    if (!cpu_as_n) begin
      low_blk_q <= (cpu_address[22:9] == '0);
    end
  end

  assign as_rise = cpu_as_n & ~as_n_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_q      <= 1'b0;
      rst_trap_q <= 1'b1;
    end else begin
      if (as_rise) begin
        hit_q <= low_blk_q;
      end
      if (trap_clr) begin
        rst_trap_q <= 1'b0;
      end
    end
  end

  always_comb begin
    fz_req  = freeze & ~freeze_q & ~active;
    brk_req = brk_en & hit_q & ~cpu_as_n & (cpu_address == BRK_ADDR);
    rst_req = rst_trap_q & ~cpu_as_n & (cpu_address == VEC_ADDR);
    req     = aron & ~boot & (fz_req | brk_req | rst_req);
    if (fz_req) begin
      cause = AR_ST_FREEZE;
    end else if (brk_req) begin
      cause = AR_ST_BREAK;
    end else begin
      cause = AR_ST_RESET;
    end
  end

endmodule

// File: rtl/ar_freeze_ctrl.sv
// Action Replay freeze entry/exit sequencer.
// Raises INT7 on an arbitrated request, waits for the autovector acknowledge,
// then enables the chip-RAM overlay and the cartridge; the cartridge code
// retires each flag by writing its exit registers.
//  clk, reset   : clock, synchronous active-low reset
//  aron, boot   : cartridge enabled / bootloader running
//  freeze       : freeze key level
//  brk_en       : breakpoint circuit enabled
//  cpu_address  : CPU word address [23:1]
//  cpu_as_n     : CPU address strobe, active-low
//  cpu_rd       : CPU read cycle
//  exit_ovl     : write to $400006 (drop overlay)
//  exit_act     : write to $400000 (leave cartridge)
//  int7         : level-7 interrupt request
//  ovl          : chip-RAM overlay enable
//  active       : cartridge ROM/RAM visible
//  status       : freeze cause
//  ack_err      : sticky, INT7 abandoned without acknowledge
module ar_freeze_ctrl
  import ar_pkg::*;
#(
  parameter logic [22:0] VEC_ADDR    = 23'h000004,
  parameter logic [22:0] BRK_ADDR    = 23'h5FF000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        aron,
  input  logic        boot,
  input  logic        freeze,
  input  logic        brk_en,
  input  logic [22:0] cpu_address,
  input  logic        cpu_as_n,
  input  logic        cpu_rd,
  input  logic        exit_ovl,
  input  logic        exit_act,
  output logic        int7,
  output logic        ovl,
  output logic        active,
  output logic [1:0]  status,
  output logic        ack_err
);

  localparam logic [7:0] TIMER_LOAD = 8'(ACK_TIMEOUT);

  ar_state_e  state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       int7_q, int7_d;
  logic       ovl_q, ovl_d;
  logic       active_q, active_d;
  logic [1:0] status_q, status_d;
  logic       ack_err_q, ack_err_d;

  logic       ack_term;
  logic       ack_q;
  logic       ack_evt;
  logic       trap_clr;
  logic       req;
  logic [1:0] cause;

  // The acknowledge counts when the qualified term ends, so a multi-clk
  // acknowledge cycle yields exactly one event.
  assign ack_term = ~cpu_as_n & cpu_rd & (cpu_address == AR_INT7_ACK_ADDR);

  always_ff @(posedge clk) begin
    ack_q <= ack_term;
  end

  assign ack_evt  = ack_q & ~ack_term;
  assign trap_clr = aron & (state_q == AR_REQ) & ack_evt;

  ar_req_arb #(
    .VEC_ADDR (VEC_ADDR),
    .BRK_ADDR (BRK_ADDR)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .aron        (aron),
    .boot        (boot),
    .freeze      (freeze),
    .brk_en      (brk_en),
    .cpu_address (cpu_address),
    .cpu_as_n    (cpu_as_n),
    .active      (active_q),
    .trap_clr    (trap_clr),
    .req         (req),
    .cause       (cause)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    int7_d    = int7_q;
    ovl_d     = ovl_q;
    active_d  = active_q;
    status_d  = status_q;
    ack_err_d = ack_err_q;
    if (!aron) begin
      state_d  = AR_IDLE;
      int7_d   = 1'b0;
      ovl_d    = 1'b0;
      active_d = 1'b0;
    end else begin
      case (state_q)
        AR_IDLE: begin
          if (req) begin
            state_d  = AR_REQ;
            int7_d   = 1'b1;
            status_d = cause;
            timer_d  = TIMER_LOAD;
          end
        end
        AR_REQ: begin
          timer_d = timer_q - 8'd1;
          // Acknowledge takes precedence over the expiring timer.
          if (ack_evt) begin
            state_d  = AR_FROZEN;
            int7_d   = 1'b0;
            ovl_d    = 1'b1;
            active_d = 1'b1;
          end else if (timer_d == '0) begin
            state_d   = AR_IDLE;
            int7_d    = 1'b0;
            ack_err_d = 1'b1;
          end
        end
        AR_FROZEN: begin
          if (exit_act) begin
            state_d  = AR_IDLE;
            ovl_d    = 1'b0;
            active_d = 1'b0;
          end else if (exit_ovl) begin
            state_d = AR_RESUME;
            ovl_d   = 1'b0;
          end
        end
        AR_RESUME: begin
          if (exit_act) begin
            state_d  = AR_IDLE;
            ovl_d    = 1'b0;
            active_d = 1'b0;
          end
        end
        default: state_d = AR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= AR_IDLE;
      timer_q   <= '0;
      int7_q    <= 1'b0;
      ovl_q     <= 1'b0;
      active_q  <= 1'b0;
      status_q  <= AR_ST_RESET;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      int7_q    <= int7_d;
      ovl_q     <= ovl_d;
      active_q  <= active_d;
      status_q  <= status_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign int7    = int7_q;
  assign ovl     = ovl_q;
  assign active  = active_q;
  assign status  = status_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_ar_freeze_ctrl.sv
// Self-checking bench for ar_freeze_ctrl: a flag-level reference model is
// stepped on every rising clock and compared with the outputs, and directed
// scenarios check hand-computed output vectors {int7,ovl,active,status,ack_err}.
module tb_ar_freeze_ctrl;

  localparam logic [22:0] VEC = 23'h000004;
  localparam logic [22:0] BRK = 23'h5FF000;
  localparam logic [22:0] ACK = 23'h7FFFFF;
  localparam int          TO  = 255;

  logic        clk = 1'b0;
  logic        reset, aron, boot, freeze, brk_en;
  logic [22:0] cpu_address;
  logic        cpu_as_n, cpu_rd, exit_ovl, exit_act;
  logic        int7, ovl, active, ack_err;
  logic [1:0]  status;

  int tests = 0;
  int fails = 0;

  ar_freeze_ctrl #(
    .VEC_ADDR    (VEC),
    .BRK_ADDR    (BRK),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .aron        (aron),
    .boot        (boot),
    .freeze      (freeze),
    .brk_en      (brk_en),
    .cpu_address (cpu_address),
    .cpu_as_n    (cpu_as_n),
    .cpu_rd      (cpu_rd),
    .exit_ovl    (exit_ovl),
    .exit_act    (exit_act),
    .int7        (int7),
    .ovl         (ovl),
    .active      (active),
    .status      (status),
    .ack_err     (ack_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (flag level) ----------------
  bit          m_valid = 0;
  bit          m_int7 = 0, m_ovl = 0, m_act = 0, m_err = 0;
  bit [1:0]    m_status = 2'b11;
  bit          m_trap = 1, m_hit = 0;
  int          m_waited = 0;
  bit          m_prev_term = 0, m_prev_fz = 0, m_prev_as = 1;
  logic [22:0] m_last_addr = '0;

  task automatic model_step();
    bit term, ack_ev, fz, brk, rs, ok;
    term   = !cpu_as_n && cpu_rd && (cpu_address == ACK);
    ack_ev = m_prev_term && !term;
    fz     = freeze && !m_prev_fz && !m_act;
    brk    = brk_en && m_hit && !cpu_as_n && (cpu_address == BRK);
    rs     = m_trap && !cpu_as_n && (cpu_address == VEC);
    ok     = aron && !boot;
    if (!reset) begin
      m_int7 = 0; m_ovl = 0; m_act = 0; m_err = 0; m_status = 2'b11;
      m_trap = 1; m_hit = 0; m_valid = 1;
    end else begin
      // previous bus cycle below byte $400 marks a hit
      if (cpu_as_n && !m_prev_as) m_hit = (m_last_addr < 23'h000200);
      if (!aron) begin
        m_int7 = 0; m_ovl = 0; m_act = 0;
      end else if (m_int7) begin
        if (ack_ev) begin
          m_int7 = 0; m_ovl = 1; m_act = 1; m_trap = 0;
        end else begin
          m_waited++;
          if (m_waited == TO) begin m_int7 = 0; m_err = 1; end
        end
      end else if (m_act) begin
        if (exit_act) begin m_ovl = 0; m_act = 0; end
        else if (exit_ovl) m_ovl = 0;
      end else if (ok && (fz || brk || rs)) begin
        m_int7 = 1; m_waited = 0;
        m_status = fz ? 2'b00 : (brk ? 2'b01 : 2'b11);
      end
    end
    m_prev_term = term;
    m_prev_fz   = freeze;
    m_prev_as   = cpu_as_n;
    if (!cpu_as_n) m_last_addr = cpu_address;
  endtask

  function automatic logic [5:0] dut_vec();
    return {int7, ovl, active, status, ack_err};
  endfunction

  function automatic logic [5:0] model_vec();
    return {m_int7, m_ovl, m_act, m_status, m_err};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_valid) begin
        tests++;
        if (dut_vec() !== model_vec()) begin
          fails++;
          $display("FAIL cycle_model t=%0t dut=%b model=%b", $time, dut_vec(), model_vec());
        end
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic expect_out(input string name, input logic [5:0] exp);
    tests++;
    if (dut_vec() !== exp) begin
      fails++;
      $display("FAIL %s dut=%b required=%b", name, dut_vec(), exp);
    end
    tests++;
    if (model_vec() !== exp) begin
      fails++;
      $display("FAIL %s_model model=%b required=%b", name, model_vec(), exp);
    end
  endtask

  task automatic bus(input logic [22:0] a, input logic rd);
    cpu_address = a; cpu_rd = rd; cpu_as_n = 1'b0;
    repeat (2) @(negedge clk);
    cpu_as_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fz_pulse();
    freeze = 1'b1;
    @(negedge clk);
    freeze = 1'b0;
  endtask

  task automatic pulse_exit(input logic o, input logic a);
    exit_ovl = o; exit_act = a;
    @(negedge clk);
    exit_ovl = 1'b0; exit_act = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; aron = 1'b0; boot = 1'b0; freeze = 1'b0; brk_en = 1'b0;
    cpu_address = '0; cpu_as_n = 1'b1; cpu_rd = 1'b0;
    exit_ovl = 1'b0; exit_act = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset_state", 6'b0_0_0_11_0);
    reset = 1'b1; aron = 1'b1;
    @(negedge clk);

    // reset trap
    cpu_address = VEC; cpu_rd = 1'b1; cpu_as_n = 1'b0;
    @(negedge clk);
    expect_out("rst_trap_int7", 6'b1_0_0_11_0);
    @(negedge clk);
    cpu_as_n = 1'b1;
    @(negedge clk);
    bus(ACK, 1'b1);
    expect_out("rst_trap_frozen", 6'b0_1_1_11_0);
    pulse_exit(1'b0, 1'b1);
    expect_out("exit_act_from_frozen", 6'b0_0_0_11_0);
    bus(VEC, 1'b1);
    expect_out("rst_trap_disarmed", 6'b0_0_0_11_0);

    // freeze button
    fz_pulse();
    expect_out("fz_int7", 6'b1_0_0_00_0);
    bus(ACK, 1'b1);
    expect_out("fz_frozen", 6'b0_1_1_00_0);
    fz_pulse();
    @(negedge clk);
    expect_out("fz_ignored_active", 6'b0_1_1_00_0);
    pulse_exit(1'b1, 1'b0);
    expect_out("exit_ovl_resume", 6'b0_0_1_00_0);
    pulse_exit(1'b0, 1'b1);
    expect_out("exit_act_idle", 6'b0_0_0_00_0);

    // breakpoint
    brk_en = 1'b1;
    bus(23'h000100, 1'b1);
    cpu_address = BRK; cpu_rd = 1'b1; cpu_as_n = 1'b0;
    @(negedge clk);
    expect_out("brk_int7", 6'b1_0_0_01_0);
    @(negedge clk);
    cpu_as_n = 1'b1;
    @(negedge clk);
    bus(ACK, 1'b1);
    expect_out("brk_frozen", 6'b0_1_1_01_0);
    pulse_exit(1'b0, 1'b1);
    bus(23'h000200, 1'b1);
    bus(BRK, 1'b1);
    expect_out("brk_no_hit", 6'b0_0_0_01_0);

    // priority: freeze edge and breakpoint access together
    bus(23'h000100, 1'b1);
    freeze = 1'b1; cpu_address = BRK; cpu_rd = 1'b1; cpu_as_n = 1'b0;
    @(negedge clk);
    expect_out("prio_fz_wins", 6'b1_0_0_00_0);
    freeze = 1'b0;
    @(negedge clk);
    cpu_as_n = 1'b1;
    @(negedge clk);
    expect_out("prio_single_int7", 6'b1_0_0_00_0);
    bus(ACK, 1'b1);
    pulse_exit(1'b1, 1'b1);
    expect_out("prio_exit_both", 6'b0_0_0_00_0);
    brk_en = 1'b0;

    // timeout
    fz_pulse();
    n = 0;
    while (int7 && n < 400) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != TO) begin
      fails++;
      $display("FAIL timeout_len int7_cycles=%0d required=%0d", n, TO);
    end
    expect_out("timeout_err", 6'b0_0_0_00_1);

    // masking
    do_reset();
    expect_out("reset_clears_err", 6'b0_0_0_11_0);
    brk_en = 1'b1; boot = 1'b1;
    fz_pulse(); bus(23'h000100, 1'b1); bus(BRK, 1'b1); bus(VEC, 1'b1);
    expect_out("boot_mask", 6'b0_0_0_11_0);
    boot = 1'b0; aron = 1'b0;
    fz_pulse(); bus(23'h000100, 1'b1); bus(BRK, 1'b1); bus(VEC, 1'b1);
    expect_out("aron_mask", 6'b0_0_0_11_0);
    aron = 1'b1; brk_en = 1'b0;
    @(negedge clk);

    // aron drop while frozen
    bus(VEC, 1'b1);
    bus(ACK, 1'b1);
    expect_out("pre_abort_frozen", 6'b0_1_1_11_0);
    aron = 1'b0;
    @(negedge clk);
    expect_out("aron_drop", 6'b0_0_0_11_0);
    aron = 1'b1;
    @(negedge clk);

    // reset while requesting
    fz_pulse();
    expect_out("fz_before_reset", 6'b1_0_0_00_0);
    reset = 1'b0;
    @(negedge clk);
    expect_out("reset_in_req", 6'b0_0_0_11_0);
    reset = 1'b1;
    @(negedge clk);

    // acknowledge lands on the final timer clk
    freeze = 1'b1;
    @(negedge clk);
    freeze = 1'b0;
    repeat (TO - 3) @(negedge clk);
    cpu_address = ACK; cpu_rd = 1'b1; cpu_as_n = 1'b0;
    repeat (2) @(negedge clk);
    cpu_as_n = 1'b1;
    @(negedge clk);
    expect_out("ack_on_last_clk", 6'b0_1_1_00_0);
    pulse_exit(1'b1, 1'b1);
    expect_out("exit_both", 6'b0_0_0_00_0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
